// File: rtl/async_fifo_gray.sv
// async_fifo_gray: dual-clock FIFO with Gray-coded pointers crossing through
// SYNC_STAGES-deep synchronisers. It provides registered full/empty flags,
// conservative occupancy counts, almost-full/almost-empty thresholds,
// overflow/underflow pulses, and either a registered or a first-word-fall-through
// read port.
module async_fifo_gray #(
    parameter int unsigned DW          = 8,
    parameter int unsigned AW          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FWFT        = 0,
    parameter int unsigned AF_LEVEL    = (1 << AW) - 2,
    parameter int unsigned AE_LEVEL    = 2
) (
    input  logic          wr_clk,
    input  logic          rd_clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          almost_full,
    output logic          overflow,
    output logic [AW:0]   wr_count,
    input  logic          rd_en,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic          empty,
    output logic          almost_empty,
    output logic          underflow,
    output logic [AW:0]   rd_count
);

    localparam int unsigned DEPTH  = 1 << AW;
    localparam logic [AW:0] AF_LVL = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_LVL = (AW+1)'(AE_LEVEL);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary bit i is the XOR of all Gray bits at i and above.
    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b = g;
        for (int unsigned s = 1; s <= AW; s++) begin
            b = b ^ (g >> s);
        end
        return b;
    endfunction

    logic [DW-1:0] mem_q [DEPTH];

    // ---------------------------------------------------------------- write side
    logic                         wr_accept;
    logic [AW:0]                  wr_bin_q, wr_bin_d;
    logic [AW:0]                  wr_gray_q, wr_gray_d;
    logic [SYNC_STAGES-1:0][AW:0] rq_sync_q;
    logic [AW:0]                  rq_gray;
    logic                         full_q, full_d;
    logic [AW:0]                  wr_count_q, wr_count_d;

    assign wr_accept = wr_en & ~full_q & ~rst;
    assign rq_gray   = rq_sync_q[SYNC_STAGES-1];

    // Next write pointer, full flag and occupancy from the synchronised read pointer.
    always_comb begin
        wr_bin_d   = wr_bin_q + (AW+1)'(wr_accept);
        wr_gray_d  = bin2gray(wr_bin_d);
        full_d     = (wr_gray_d == {~rq_gray[AW:AW-1], rq_gray[AW-2:0]});
        wr_count_d = wr_bin_d - gray2bin(rq_gray);
    end

    // Write-domain pointer, flag and read-pointer synchroniser registers.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            wr_bin_q   <= '0;
            wr_gray_q  <= '0;
            rq_sync_q  <= '0;
            full_q     <= 1'b0;
            wr_count_q <= '0;
        end else begin
            wr_bin_q   <= wr_bin_d;
            wr_gray_q  <= wr_gray_d;
            rq_sync_q  <= {rq_sync_q[SYNC_STAGES-2:0], rd_gray_q};
            full_q     <= full_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Storage write port.
    always_ff @(posedge wr_clk) begin
        if (wr_accept) begin
            mem_q[wr_bin_q[AW-1:0]] <= din;
        end
    end

    assign full        = full_q;
    assign almost_full = (wr_count_q >= AF_LVL);
    assign overflow    = wr_en & full_q;
    assign wr_count    = wr_count_q;

    // ----------------------------------------------------------------- read side
    logic [SYNC_STAGES-1:0]       rst_sync_q;
    logic                         rd_rst;
    logic                         rd_accept;
    logic [AW:0]                  rd_bin_q, rd_bin_d;
    logic [AW:0]                  rd_gray_q, rd_gray_d;
    logic [SYNC_STAGES-1:0][AW:0] wq_sync_q;
    logic [AW:0]                  wq_gray;
    logic                         empty_q, empty_d;
    logic [AW:0]                  rd_count_q, rd_count_d;

    // Carry the write-domain reset into the read domain.
    always_ff @(posedge rd_clk) begin
        rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], rst};
    end

    assign rd_rst    = rst_sync_q[SYNC_STAGES-1];
    assign rd_accept = rd_en & ~empty_q & ~rd_rst;
    assign wq_gray   = wq_sync_q[SYNC_STAGES-1];

    // Next read pointer, empty flag and occupancy from the synchronised write pointer.
    always_comb begin
        rd_bin_d   = rd_bin_q + (AW+1)'(rd_accept);
        rd_gray_d  = bin2gray(rd_bin_d);
        empty_d    = (rd_gray_d == wq_gray);
        rd_count_d = gray2bin(wq_gray) - rd_bin_d;
    end

    // Read-domain pointer, flag and write-pointer synchroniser registers.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_bin_q   <= '0;
            rd_gray_q  <= '0;
            wq_sync_q  <= '0;
            empty_q    <= 1'b1;
            rd_count_q <= '0;
        end else begin
            rd_bin_q   <= rd_bin_d;
            rd_gray_q  <= rd_gray_d;
            wq_sync_q  <= {wq_sync_q[SYNC_STAGES-2:0], wr_gray_q};
            empty_q    <= empty_d;
            rd_count_q <= rd_count_d;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout  = mem_q[rd_bin_q[AW-1:0]];
            assign valid = ~empty_q;
        end else begin : g_std
            logic [DW-1:0] dout_q;
            logic          valid_q;

            // Registered read port: load on an accepted pop, hold otherwise.
            always_ff @(posedge rd_clk) begin
                if (rd_rst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_accept;
                    if (rd_accept) begin
                        dout_q <= mem_q[rd_bin_q[AW-1:0]];
                    end
                end
            end

            assign dout  = dout_q;
            assign valid = valid_q;
        end
    endgenerate

    assign empty        = empty_q;
    assign almost_empty = (rd_count_q <= AE_LVL);
    assign underflow    = rd_en & empty_q;
    assign rd_count     = rd_count_q;

endmodule

// File: tb/tb_async_fifo_gray.sv
// tb_async_fifo_gray: directed checks of async_fifo_gray in standard and FWFT
// read modes, followed by a randomised run across unrelated clocks.
module tb_async_fifo_gray;

    int wr_half = 5;
    int rd_half = 5;

    logic       wr_clk = 1'b0;
    logic       rd_clk = 1'b0;
    logic       rst;

    logic       wr_en, rd_en;
    logic [7:0] din, dout;
    logic       full, almost_full, overflow, valid, empty, almost_empty, underflow;
    logic [4:0] wr_count, rd_count;

    logic       f_wr_en, f_rd_en;
    logic [7:0] f_din, f_dout;
    logic       f_full, f_almost_full, f_overflow, f_valid, f_empty, f_almost_empty, f_underflow;
    logic [4:0] f_wr_count, f_rd_count;

    int passed = 0;
    int total  = 0;

    always #wr_half wr_clk = ~wr_clk;
    always #rd_half rd_clk = ~rd_clk;

    async_fifo_gray #(
        .DW(8), .AW(4), .SYNC_STAGES(2), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)
    ) dut (
        .wr_clk(wr_clk), .rd_clk(rd_clk), .rst(rst),
        .wr_en(wr_en), .din(din), .full(full), .almost_full(almost_full),
        .overflow(overflow), .wr_count(wr_count),
        .rd_en(rd_en), .dout(dout), .valid(valid), .empty(empty),
        .almost_empty(almost_empty), .underflow(underflow), .rd_count(rd_count)
    );

    async_fifo_gray #(
        .DW(8), .AW(4), .SYNC_STAGES(2), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)
    ) dut_f (
        .wr_clk(wr_clk), .rd_clk(rd_clk), .rst(rst),
        .wr_en(f_wr_en), .din(f_din), .full(f_full), .almost_full(f_almost_full),
        .overflow(f_overflow), .wr_count(f_wr_count),
        .rd_en(f_rd_en), .dout(f_dout), .valid(f_valid), .empty(f_empty),
        .almost_empty(f_almost_empty), .underflow(f_underflow), .rd_count(f_rd_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Wait (bounded) for the standard instance to show data; returns rd_clk edges waited.
    task automatic wait_rd_data(output int n);
        n = 0;
        while (empty && n < 10) begin
            @(posedge rd_clk); #1;
            n++;
        end
    endtask

    localparam int unsigned N_WORDS = 3000;
    logic [7:0]  sb[$];
    int unsigned got_words, data_err, rc_err, max_wc;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        wr_en = 0; din = 0; rd_en = 0;
        f_wr_en = 0; f_din = 0; f_rd_en = 0;
        rst = 1;
        repeat (8) @(posedge wr_clk);
        #1 rst = 0;
        repeat (5) @(posedge wr_clk);
        #1;

        // reset state
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_wc", wr_count, 0);
        check("rst_rc", rd_count, 0);
        check("rst_valid", valid, 0);
        check("rst_dout", dout, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_af", almost_full, 0);

        // single word: empty latency and one-cycle read latency
        din = 8'hA5; wr_en = 1;
        @(posedge wr_clk); #1;
        wr_en = 0;
        check("wc_one", wr_count, 1);
        check("empty_hold", empty, 1);
        wait_rd_data(n);
        check("empty_lat", n, 3);
        check("rc_one", rd_count, 1);
        rd_en = 1;
        @(posedge rd_clk); #1;
        rd_en = 0;
        check("rd_dout", dout, 8'hA5);
        check("rd_valid", valid, 1);
        check("rd_empty", empty, 1);
        @(posedge rd_clk); #1;
        check("valid_drop", valid, 0);

        // fill to full
        repeat (6) @(posedge wr_clk);
        #1;
        check("wc_settled", wr_count, 0);
        for (int k = 1; k <= 16; k++) begin
            din = 8'(k - 1); wr_en = 1;
            @(posedge wr_clk); #1;
            if (k == 13) check("af_13", almost_full, 0);
            if (k == 14) check("af_14", almost_full, 1);
            if (k == 15) check("full_15", full, 0);
            if (k == 16) begin
                check("full_16", full, 1);
                check("wc_16", wr_count, 16);
            end
        end
        din = 8'hEE;
        #1;
        check("ovf_pulse", overflow, 1);
        @(posedge wr_clk); #1;
        wr_en = 0;
        #1;
        check("ovf_clear", overflow, 0);
        check("full_keep", full, 1);
        check("wc_keep", wr_count, 16);
        repeat (4) @(posedge rd_clk);
        #1;
        check("rc_16", rd_count, 16);
        check("ae_full", almost_empty, 0);

        // drain in order
        rd_en = 1;
        for (int j = 1; j <= 16; j++) begin
            @(posedge rd_clk); #1;
            check("drain_dout", dout, 8'(j - 1));
            if (j == 3)  check("full_lat3", full, 1);
            if (j == 4)  check("full_lat4", full, 0);
            if (j == 13) check("ae_13", almost_empty, 0);
            if (j == 14) check("ae_14", almost_empty, 1);
        end
        rd_en = 0;
        check("drain_empty", empty, 1);

        // underflow
        #1 rd_en = 1;
        #1;
        check("udf_pulse", underflow, 1);
        @(posedge rd_clk); #1;
        rd_en = 0;
        #1;
        check("udf_clear", underflow, 0);
        check("udf_valid", valid, 0);
        check("udf_dout", dout, 8'h0F);
        check("udf_rc", rd_count, 0);
        @(posedge wr_clk); #1;
        din = 8'h5A; wr_en = 1;
        @(posedge wr_clk); #1;
        wr_en = 0;
        wait_rd_data(n);
        check("udf_lat", n, 3);
        rd_en = 1;
        @(posedge rd_clk); #1;
        rd_en = 0;
        check("udf_next", dout, 8'h5A);

        // FWFT instance
        f_din = 8'h3C; f_wr_en = 1;
        @(posedge wr_clk); #1;
        f_wr_en = 0;
        n = 0;
        while (f_empty && n < 10) begin
            @(posedge rd_clk); #1;
            n++;
        end
        check("fw_lat", n, 3);
        check("fw_dout", f_dout, 8'h3C);
        check("fw_valid", f_valid, 1);
        f_din = 8'h3D; f_wr_en = 1;
        @(posedge wr_clk); #1;
        f_wr_en = 0;
        repeat (5) @(posedge rd_clk);
        #1;
        check("fw_hold", f_dout, 8'h3C);
        f_rd_en = 1;
        @(posedge rd_clk); #1;
        f_rd_en = 0;
        check("fw_next", f_dout, 8'h3D);
        check("fw_valid2", f_valid, 1);
        f_rd_en = 1;
        @(posedge rd_clk); #1;
        f_rd_en = 0;
        check("fw_valid0", f_valid, 0);
        check("fw_empty", f_empty, 1);

        // reset with 9 words stored and traffic active
        for (int k = 0; k < 9; k++) begin
            din = 8'(8'h80 + k); wr_en = 1;
            @(posedge wr_clk); #1;
        end
        din = 8'hC0; rd_en = 1;
        repeat (2) @(posedge wr_clk);
        #1 rst = 1;
        repeat (8) @(posedge wr_clk);
        #1 rst = 0; wr_en = 0; rd_en = 0;
        repeat (6) @(posedge wr_clk);
        #1;
        check("mrst_empty", empty, 1);
        check("mrst_full", full, 0);
        check("mrst_wc", wr_count, 0);
        check("mrst_rc", rd_count, 0);
        check("mrst_valid", valid, 0);
        check("mrst_dout", dout, 0);
        rd_en = 1;
        repeat (2) @(posedge rd_clk);
        #1 rd_en = 0;
        check("mrst_rd_valid", valid, 0);
        check("mrst_rd_dout", dout, 0);
        din = 8'h11; wr_en = 1;
        @(posedge wr_clk); #1;
        wr_en = 0;
        wait_rd_data(n);
        check("mrst_lat", n, 3);
        rd_en = 1;
        @(posedge rd_clk); #1;
        rd_en = 0;
        check("mrst_new", dout, 8'h11);
        check("mrst_new_valid", valid, 1);

        // unrelated clocks, random traffic
        rd_half = 14;
        repeat (20) @(posedge rd_clk);
        got_words = 0; data_err = 0; rc_err = 0; max_wc = 0;
        fork
            begin : writer
                int unsigned sent, cyc;
                logic [7:0]  wd;
                logic        acc;
                sent = 0; cyc = 0; wd = 8'h00;
                @(posedge wr_clk); #1;
                while (sent < N_WORDS && cyc < 40 * N_WORDS) begin
                    wr_en = 1'($urandom_range(0, 1));
                    din   = wd;
                    acc   = wr_en & ~full;
                    @(posedge wr_clk);
                    cyc++;
                    if (acc) begin
                        sb.push_back(wd);
                        wd++;
                        sent++;
                    end
                    #1;
                    if (wr_count > max_wc) max_wc = wr_count;
                end
                wr_en = 0;
            end
            begin : reader
                int unsigned cyc;
                logic        acc;
                logic [7:0]  exp_w;
                cyc = 0;
                @(posedge rd_clk); #1;
                while (got_words < N_WORDS && cyc < 20 * N_WORDS) begin
                    rd_en = ($urandom_range(0, 3) != 0);
                    acc   = rd_en & ~empty;
                    @(posedge rd_clk); #1;
                    cyc++;
                    if (acc) begin
                        if (sb.size() == 0) data_err++;
                        else begin
                            exp_w = sb.pop_front();
                            if (dout !== exp_w || valid !== 1'b1) data_err++;
                        end
                        got_words++;
                    end
                    if (int'(rd_count) > sb.size()) rc_err++;
                end
                rd_en = 0;
            end
        join
        check("cdc_words", got_words, N_WORDS);
        check("cdc_data_err", data_err, 0);
        check("cdc_rc_over", rc_err, 0);
        check("cdc_wc_le16", (max_wc <= 16) ? 1 : 0, 1);
        check("cdc_leftover", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
